cell_bist_engine: RTL and testbench
===================================

Name: cell_bist_engine

Overview:
Built-in self-test engine for one library cell instance (INV, NAND2…AOI22, MUX2, DFF/DFFE) in the techlib characterisation harness. It sits directly upstream of the cell under test (CUT) and drives exhaustive input patterns into it. It also sits directly downstream of the CUT: it consumes the CUT output Y and compacts it into a MISR signature, which is compared against a golden value. Result is pass/fail plus the raw signature for tool-side debug.

Parameters:
N_IN, 4, maximum CUT input count; width of cut_in.
MISR_W, 16, signature width; fixed polynomial below is defined for 16 only.
CUT_LAT, 0, CUT latency in cycles (0 = combinational cell, 1 = DFF/DFFE); legal range 0..3.

Ports:
CLK  in  1  clock, all state on rising edge.
RST  in  1  reset, asynchronous, active-high.
start  in  1  begin a run; sampled only in IDLE.
abort  in  1  terminate a run; return to IDLE with no done.
n_inputs  in  3  number of CUT inputs exercised, 1..N_IN.
golden  in  MISR_W  expected signature, sampled at start.
cut_in  out  N_IN  pattern to CUT; bits at index >= n_inputs driven 0.
cut_y  in  1  CUT response.
busy  out  1  high from the cycle after start through DRAIN.
done  out  1  one-cycle pulse when signature is final.
pass  out  1  signature==golden_q; valid from done, held until next start.
signature  out  MISR_W  MISR contents; held after done.
cfg_err  out  1  one-cycle pulse: start with n_inputs==0 or >N_IN (run not started).

Behaviour:
- Reset values: cut_in=0, busy=0, done=0, pass=0, cfg_err=0, signature=16'hFFFF, state=IDLE, pipe valid bits=0.
- States: IDLE, APPLY, DRAIN, DONE.
- IDLE + start + legal n_inputs:
  - At the edge: cut_in<=0, signature<=16'hFFFF, golden_q<=golden, n_q<=n_inputs, pass<=0, go APPLY.
  - With illegal n_inputs: cfg_err pulse, stay IDLE.
- APPLY: pattern k (k=0..2^n_q-1) is on cut_in during the k-th APPLY cycle.
  - Each edge pushes a valid token into a CUT_LAT-deep delay pipe, then increments cut_in.
  - After pattern 2^n_q-1: cut_in<=0; go DRAIN if CUT_LAT>0, else DONE.
- Response capture: the response for the pattern presented in cycle c is cut_y sampled at the edge ending cycle c+CUT_LAT. The MISR updates only on edges where the delayed valid is set.
- MISR (Fibonacci, x^16+x^14+x^13+x^11+1):
  - fb = sig[15]^sig[13]^sig[12]^sig[10]^cut_y
  - sig <= {sig[14:0], fb}
- DRAIN: lasts exactly CUT_LAT cycles; only MISR updates occur; cut_in holds 0.
- DONE: done=1 and pass=(sig==golden_q) for one cycle, then IDLE. signature and pass hold.
- Latency: start edge to done-high cycle = 2^n_q + CUT_LAT + 1 cycles.
- busy is high in APPLY and DRAIN, low in DONE and IDLE.
- start while not IDLE: ignored.
- abort in any non-IDLE state: next edge IDLE, cut_in=0, busy=0, no done, signature keeps its partial value, pass=0. abort has priority over the final-pattern transition.
- RST mid-run: immediate return to all reset values, including signature=FFFF.
- n_q latched at start; later n_inputs changes have no effect on the current run.

Decomposition:
- Package cell_bist_pkg: state enum, MISR_SEED=16'hFFFF, MISR tap mask 16'hB400 (taps 15, 13, 12, 10), MAX_CUT_LAT=3.
- One sub-module: bist_misr. Inputs: clk, rst, init, en, d. Output: sig. Instantiated once; FSM, pattern counter and latency pipe live in the top.

Test Plan:
- CUT=constant 0, n_inputs=1, CUT_LAT=0 -> cut_in 0,1 over 2 cycles; signature=16'hFFFC; done at start+3; pass=1 when golden=16'hFFFC.
- CUT=INV on cut_in[0], n_inputs=1, golden=16'hFFFE -> signature=16'hFFFE, pass=1. Same run with golden=16'hFFFC -> pass=0.
- CUT=NAND4, n_inputs=4 -> cut_in walks 0..15 in 16 cycles; done at start+17; bench-model MISR matches. Stuck-at-1 fault injected on Y -> pass=0.
- CUT=DFF, CUT_LAT=1, n_inputs=1 -> responses aligned one cycle late; one DRAIN cycle; done at start+4; signature equals the INV-style model on the delayed data.
- start with n_inputs=0 and with n_inputs=5 -> cfg_err pulse, busy stays 0. start during APPLY -> ignored. abort at pattern 3 of NAND2 run -> IDLE next cycle, no done.
- RST asserted asynchronously mid-APPLY -> outputs return to reset values the same cycle; a fresh start afterwards yields the normal signature.

Source files
------------

// File: rtl/cell_bist_pkg.sv
// Shared types and constants for the cell BIST engine: FSM states,
// MISR seed/tap definition and the single-step MISR update.
package cell_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          SIG_W       = 16;
    localparam logic [15:0] MISR_SEED   = 16'hFFFF;
    localparam logic [15:0] MISR_TAPS   = 16'hB400;
    localparam int          MAX_CUT_LAT = 3;

    // Fibonacci step for x^16+x^14+x^13+x^11+1 with the response folded into the feedback.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic d);
        return {sig[SIG_W-2:0], (^(sig & MISR_TAPS)) ^ d};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Signature register: seeded on init, advanced by one response bit when en is set.
// sig_next_o exposes the value being loaded so the pass compare can see the final update.
module bist_misr
    import cell_bist_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_i,
    input  logic             en_i,
    input  logic             d_i,
    output logic [SIG_W-1:0] sig_o,
    output logic [SIG_W-1:0] sig_next_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Next signature: init wins over a response update.
    always_comb begin
        sig_d = sig_q;
        if (init_i) begin
            sig_d = MISR_SEED;
        end else if (en_i) begin
            sig_d = misr_step(sig_q, d_i);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/cell_bist_engine.sv
// Exhaustive-pattern BIST for one library cell: walks cut_in over 2^n patterns,
// compacts the CUT response (delayed by CUT_LAT) into a MISR and flags pass/fail.
module cell_bist_engine
    import cell_bist_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int MISR_W  = 16,
    parameter int CUT_LAT = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [2:0]        n_inputs_i,
    input  logic [MISR_W-1:0] golden_i,
    output logic [N_IN-1:0]   cut_in_o,
    input  logic              cut_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [MISR_W-1:0] signature_o,
    output logic              cfg_err_o
);

    localparam logic [MAX_CUT_LAT:0] LAT_SEL  = {{MAX_CUT_LAT{1'b0}}, 1'b1} << CUT_LAT;
    localparam logic [1:0]           LAT_LAST = 2'(CUT_LAT - 1);

    state_t                 state_q, state_d;
    logic [N_IN-1:0]        cut_in_q, cut_in_d;
    logic [2:0]             n_q, n_d;
    logic [MISR_W-1:0]      golden_q, golden_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [1:0]             lat_cnt_q, lat_cnt_d;
    logic [MAX_CUT_LAT-1:0] vpipe_q, vpipe_d;
    logic [MAX_CUT_LAT:0]   vtap_s;
    logic [N_IN-1:0]        pat_max_s;
    logic [MISR_W-1:0]      sig_s, sig_next_s;
    logic                   n_ok_s, push_s, flush_s, misr_init_s, misr_en_s;

    assign n_ok_s      = (n_inputs_i != 3'd0) && ({29'd0, n_inputs_i} <= 32'(N_IN));
    assign pat_max_s   = ~({N_IN{1'b1}} << n_q);
    assign flush_s     = abort_i && (state_q != ST_IDLE);
    assign push_s      = (state_q == ST_APPLY) && !abort_i;
    assign misr_init_s = (state_q == ST_IDLE) && start_i && n_ok_s;

    // Valid tokens ride a shift line; the tap at depth CUT_LAT marks a response to compact.
    assign vtap_s    = {vpipe_q, push_s};
    assign vpipe_d   = flush_s ? {MAX_CUT_LAT{1'b0}} : vtap_s[MAX_CUT_LAT-1:0];
    assign misr_en_s = (|(vtap_s & LAT_SEL)) && !flush_s;

    bist_misr u_misr (
        .clk_i      (CLK),
        .rst_i      (RST),
        .init_i     (misr_init_s),
        .en_i       (misr_en_s),
        .d_i        (cut_y_i),
        .sig_o      (sig_s),
        .sig_next_o (sig_next_s)
    );

    // Next-state and registered-output logic; abort overrides every running state.
    always_comb begin
        state_d   = state_q;
        cut_in_d  = cut_in_q;
        n_d       = n_q;
        golden_d  = golden_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        cfg_err_d = 1'b0;
        lat_cnt_d = lat_cnt_q;
        if (flush_s) begin
            state_d   = ST_IDLE;
            cut_in_d  = {N_IN{1'b0}};
            busy_d    = 1'b0;
            pass_d    = 1'b0;
            lat_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && n_ok_s) begin
                        state_d   = ST_APPLY;
                        cut_in_d  = {N_IN{1'b0}};
                        n_d       = n_inputs_i;
                        golden_d  = golden_i;
                        busy_d    = 1'b1;
                        pass_d    = 1'b0;
                        lat_cnt_d = 2'd0;
                    end else if (start_i) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (cut_in_q == pat_max_s) begin
                        cut_in_d = {N_IN{1'b0}};
                        if (CUT_LAT > 0) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (sig_next_s == golden_q);
                        end
                    end else begin
                        cut_in_d = cut_in_q + {{(N_IN-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (sig_next_s == golden_q);
                        lat_cnt_d = 2'd0;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cut_in_q  <= {N_IN{1'b0}};
            n_q       <= 3'd0;
            golden_q  <= {MISR_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            lat_cnt_q <= 2'd0;
            vpipe_q   <= {MAX_CUT_LAT{1'b0}};
        end else begin
            state_q   <= state_d;
            cut_in_q  <= cut_in_d;
            n_q       <= n_d;
            golden_q  <= golden_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            cfg_err_q <= cfg_err_d;
            lat_cnt_q <= lat_cnt_d;
            vpipe_q   <= vpipe_d;
        end
    end

    assign cut_in_o    = cut_in_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign signature_o = sig_s;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_cell_bist_engine.sv
// Bench for cell_bist_engine: one combinational-CUT instance (CUT_LAT=0) and one DFF-CUT
// instance (CUT_LAT=1), driven from a table of runs plus hand-written corner sequences.
module tb_cell_bist_engine;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start0, start1, abort;
    logic [2:0]  n_inputs;
    logic [15:0] golden;
    logic [3:0]  cut_in0, cut_in1;
    logic        cut_y0, cut_y1, dff_q;
    logic        busy0, busy1, done0, done1, pass0, pass1, cfg_err0, cfg_err1;
    logic [15:0] sig0, sig1;
    int          mode;
    int          cut_n;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    // CUT models: 0 const0, 1 INV(a0), 2 NAND over n inputs, 3 stuck-at-1, 4 BUF(a0)
    function automatic logic cut_fn(input int m, input int n, input logic [3:0] p);
        logic all1;
        all1 = 1'b1;
        for (int i = 0; i < n; i++) all1 = all1 & p[i];
        case (m)
            0:       return 1'b0;
            1:       return ~p[0];
            2:       return ~all1;
            3:       return 1'b1;
            default: return p[0];
        endcase
    endfunction

    function automatic logic [15:0] model_sig(input int m, input int n);
        logic [15:0] s;
        logic        y;
        s = 16'hFFFF;
        for (int k = 0; k < (1 << n); k++) begin
            y = cut_fn(m, n, 4'(k));
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ y};
        end
        return s;
    endfunction

    assign cut_y0 = cut_fn(mode, cut_n, cut_in0);
    assign cut_y1 = dff_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) dff_q <= 1'b0;
        else     dff_q <= cut_fn(mode, cut_n, cut_in1);
    end

    cell_bist_engine #(.N_IN(4), .MISR_W(16), .CUT_LAT(0)) dut0 (
        .CLK(CLK), .RST(RST), .start_i(start0), .abort_i(abort), .n_inputs_i(n_inputs),
        .golden_i(golden), .cut_in_o(cut_in0), .cut_y_i(cut_y0), .busy_o(busy0),
        .done_o(done0), .pass_o(pass0), .signature_o(sig0), .cfg_err_o(cfg_err0));

    cell_bist_engine #(.N_IN(4), .MISR_W(16), .CUT_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .start_i(start1), .abort_i(abort), .n_inputs_i(n_inputs),
        .golden_i(golden), .cut_in_o(cut_in1), .cut_y_i(cut_y1), .busy_o(busy1),
        .done_o(done1), .pass_o(pass1), .signature_o(sig1), .cfg_err_o(cfg_err1));

    typedef struct {
        int          lat;
        int          mode;
        int          n;
        logic [15:0] golden;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   c;
        logic walk_ok, busy_ok;
        mode     = v.mode;
        cut_n    = v.n;
        n_inputs = 3'(v.n);
        golden   = v.golden;
        @(negedge CLK);
        if (v.lat == 1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        start1 = 1'b0;
        c = 1; walk_ok = 1'b1; busy_ok = 1'b1;
        while (((v.lat == 1) ? done1 : done0) !== 1'b1 && c < 200) begin
            if (c <= (1 << v.n) && ((v.lat == 1) ? cut_in1 : cut_in0) !== 4'(c - 1)) walk_ok = 1'b0;
            if (((v.lat == 1) ? busy1 : busy0) !== 1'b1) busy_ok = 1'b0;
            @(negedge CLK);
            c++;
        end
        chk($sformatf("v%0d latency", idx), 32'(c), 32'((1 << v.n) + v.lat + 1));
        chk($sformatf("v%0d walk", idx), {31'd0, walk_ok}, 32'd1);
        chk($sformatf("v%0d busy", idx), {30'd0, busy_ok, ((v.lat == 1) ? busy1 : busy0)}, 32'd2);
        chk($sformatf("v%0d signature", idx), {16'd0, ((v.lat == 1) ? sig1 : sig0)}, {16'd0, v.exp_sig});
        chk($sformatf("v%0d pass", idx), {31'd0, ((v.lat == 1) ? pass1 : pass0)}, {31'd0, v.exp_pass});
        @(negedge CLK);
        chk($sformatf("v%0d hold", idx),
            {15'd0, ((v.lat == 1) ? done1 : done0), ((v.lat == 1) ? sig1 : sig0)},
            {15'd0, 1'b0, v.exp_sig});
        chk($sformatf("v%0d pass hold", idx), {31'd0, ((v.lat == 1) ? pass1 : pass0)}, {31'd0, v.exp_pass});
    endtask

    initial begin
        int   c;
        logic saw_done;
        vecs[0] = '{0, 0, 1, 16'hFFFC, 16'hFFFC, 1'b1};
        vecs[1] = '{0, 1, 1, 16'hFFFE, 16'hFFFE, 1'b1};
        vecs[2] = '{0, 1, 1, 16'hFFFC, 16'hFFFE, 1'b0};
        vecs[3] = '{0, 2, 4, model_sig(2, 4), model_sig(2, 4), 1'b1};
        vecs[4] = '{0, 3, 4, model_sig(2, 4), model_sig(3, 4), 1'b0};
        vecs[5] = '{1, 4, 1, 16'hFFFD, 16'hFFFD, 1'b1};
        vecs[6] = '{1, 2, 2, model_sig(2, 2), model_sig(2, 2), 1'b1};

        RST = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        n_inputs = 3'd1; golden = 16'h0000; mode = 0; cut_n = 1;
        repeat (2) @(negedge CLK);
        chk("reset dut0", {cut_in0, busy0, done0, pass0, cfg_err0, sig0}, {4'd0, 4'd0, 16'hFFFF});
        chk("reset dut1", {cut_in1, busy1, done1, pass1, cfg_err1, sig1}, {4'd0, 4'd0, 16'hFFFF});
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Illegal n_inputs: cfg_err pulse, run never starts
        for (int j = 0; j < 2; j++) begin
            n_inputs = (j == 0) ? 3'd0 : 3'd5;
            start0 = 1'b1;
            @(negedge CLK);
            start0 = 1'b0;
            chk($sformatf("cfg_err n=%0d", n_inputs), {30'd0, cfg_err0, busy0}, 32'd2);
            @(negedge CLK);
            chk($sformatf("cfg_err clear n=%0d", n_inputs), {30'd0, cfg_err0, busy0}, 32'd0);
        end

        // start during APPLY (with a new n_inputs) must be ignored
        mode = 2; cut_n = 2; n_inputs = 3'd2; golden = model_sig(2, 2);
        start0 = 1'b1;
        @(negedge CLK);
        n_inputs = 3'd4;
        @(negedge CLK);
        start0 = 1'b0;
        c = 2;
        while (done0 !== 1'b1 && c < 50) begin
            @(negedge CLK);
            c++;
        end
        n_inputs = 3'd2;
        chk("restart ignored latency", 32'(c), 32'd5);
        chk("restart ignored sig", {16'd0, sig0}, {16'd0, model_sig(2, 2)});
        chk("restart ignored pass", {31'd0, pass0}, 32'd1);
        @(negedge CLK);

        // abort on the final pattern of a NAND2 run wins over the DONE transition
        start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        c = 1;
        while (cut_in0 !== 4'd3 && c < 20) begin
            @(negedge CLK);
            c++;
        end
        chk("abort at pattern 3", 32'(c), 32'd4);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort outputs", {28'd0, cut_in0 != 4'd0, busy0, done0, pass0}, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (done0 === 1'b1 || busy0 === 1'b1) saw_done = 1'b1;
        end
        chk("abort no done", {31'd0, saw_done}, 32'd0);

        // asynchronous RST mid-APPLY, then a fresh NAND4 run
        mode = 2; cut_n = 4; n_inputs = 3'd4; golden = model_sig(2, 4);
        start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst mid-run", {cut_in0, busy0, done0, pass0, cfg_err0, sig0}, {4'd0, 4'd0, 16'hFFFF});
        @(negedge CLK);
        RST = 1'b0;
        run_vec(vecs[3], 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
